rf_wb_arbiter: RTL and testbench

Controller for the single write port of the core's 32x`XLEN register file. It shares that port between the in-order pipeline writeback and the multi-cycle MUL/DIV unit (MDU), and keeps a scoreboard of registers with MDU results still pending. Decode uses the scoreboard to stall on RAW and WAW hazards. The block sits between WB/MDU and the regfile, and feeds busy/stall flags back to decode and the hazard unit.

---
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 tb/tb_rf_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and the MDU,
// and tracks registers whose MDU results are still outstanding.
`ifndef XLEN
`define XLEN 32
`endif

module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_we_i,
    input  logic [4:0]        pipe_rd_addr_i,
    input  logic [`XLEN-1:0]  pipe_rd_data_i,
    input  logic              mdu_valid_i,
    input  logic [4:0]        mdu_rd_addr_i,
    input  logic [`XLEN-1:0]  mdu_rd_data_i,
    output logic              mdu_ready_o,
    input  logic              issue_i,
    input  logic [4:0]        issue_rd_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic [4:0]        rd_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              rd_busy_o,
    output logic              wb_stall_o,
    output logic              rd_we_o,
    output logic [4:0]        rd_addr_o,
    output logic [`XLEN-1:0]  rd_data_o
);

    localparam logic [CNT_W-1:0] STARVE_TOP  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             mdu_grant;
    logic             mdu_denied;

    // The pipeline has absolute priority; the MDU only gets idle cycles.
    assign mdu_grant  = mdu_valid_i & ~pipe_we_i;
    assign mdu_denied = mdu_valid_i & pipe_we_i;
    assign mdu_ready_o = mdu_grant;

    always_comb begin
        rd_we_o   = 1'b0;
        rd_addr_o = 5'd0;
        rd_data_o = '0;
        if (pipe_we_i) begin
            rd_we_o   = 1'b1;
            rd_addr_o = pipe_rd_addr_i;
            rd_data_o = pipe_rd_data_i;
        end else if (mdu_valid_i) begin
            rd_we_o   = (mdu_rd_addr_i != 5'd0);
            rd_addr_o = mdu_rd_addr_i;
            rd_data_o = mdu_rd_data_i;
        end
    end

    // Clear first, then set, so a new issue wins over a same-cycle commit.
    always_comb begin
        busy_next = busy;
        if (mdu_grant)
            busy_next[mdu_rd_addr_i] = 1'b0;
        if (issue_i && (issue_rd_i != 5'd0))
            busy_next[issue_rd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // A register is no longer busy in the cycle its result commits.
    always_comb begin
        rs1_busy_o = busy[rs1_addr_i] & ~(mdu_grant && (mdu_rd_addr_i == rs1_addr_i));
        rs2_busy_o = busy[rs2_addr_i] & ~(mdu_grant && (mdu_rd_addr_i == rs2_addr_i));
        rd_busy_o  = busy[rd_addr_i]  & ~(mdu_grant && (mdu_rd_addr_i == rd_addr_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy       <= '0;
            starve_cnt <= '0;
            wb_stall_o <= 1'b0;
        end else begin
            busy <= busy_next;
            if (mdu_denied) begin
                if (starve_cnt != STARVE_TOP)
                    starve_cnt <= starve_cnt + 1'b1;
                if (starve_cnt == STARVE_LAST)
                    wb_stall_o <= 1'b1;
            end else begin
                starve_cnt <= '0;
                wb_stall_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, scoreboard, starvation stall
// and reset, with hand-computed expectations.
`ifndef XLEN
`define XLEN 32
`endif

module tb_rf_wb_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_we;
    logic [4:0]        pipe_rd_addr;
    logic [`XLEN-1:0]  pipe_rd_data;
    logic              mdu_valid;
    logic [4:0]        mdu_rd_addr;
    logic [`XLEN-1:0]  mdu_rd_data;
    logic              mdu_ready;
    logic              issue;
    logic [4:0]        issue_rd;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;
    logic              wb_stall;
    logic              rd_we;
    logic [4:0]        rd_addr_out;
    logic [`XLEN-1:0]  rd_data_out;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int check_cnt = 0;

    rf_wb_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pipe_we_i      (pipe_we),
        .pipe_rd_addr_i (pipe_rd_addr),
        .pipe_rd_data_i (pipe_rd_data),
        .mdu_valid_i    (mdu_valid),
        .mdu_rd_addr_i  (mdu_rd_addr),
        .mdu_rd_data_i  (mdu_rd_data),
        .mdu_ready_o    (mdu_ready),
        .issue_i        (issue),
        .issue_rd_i     (issue_rd),
        .rs1_addr_i     (rs1_addr),
        .rs2_addr_i     (rs2_addr),
        .rd_addr_i      (rd_addr),
        .rs1_busy_o     (rs1_busy),
        .rs2_busy_o     (rs2_busy),
        .rd_busy_o      (rd_busy),
        .wb_stall_o     (wb_stall),
        .rd_we_o        (rd_we),
        .rd_addr_o      (rd_addr_out),
        .rd_data_o      (rd_data_out)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(
        input logic pw, input logic [4:0] pa, input logic [31:0] pd,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic iss, input logic [4:0] ir,
        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        pipe_we = pw; pipe_rd_addr = pa; pipe_rd_data = pd;
        mdu_valid = mv; mdu_rd_addr = ma; mdu_rd_data = md;
        issue = iss; issue_rd = ir;
        rs1_addr = s1; rs2_addr = s2; rd_addr = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 7);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 7);
        checkOutput("reset_stall", wb_stall, 0);
        checkOutput("reset_rs1_busy", rs1_busy, 0);
        checkOutput("reset_rd_we", rd_we, 0);
        checkOutput("reset_ready", mdu_ready, 0);

        // Issue to x5, then commit it from the MDU.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        checkOutput("t1_rs1_busy", rs1_busy, 1);
        checkOutput("t1_idle_addr", rd_addr_out, 0);
        checkOutput("t1_idle_data", rd_data_out, 0);
        applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0);
        checkOutput("t1_ready", mdu_ready, 1);
        checkOutput("t1_we", rd_we, 1);
        checkOutput("t1_addr", rd_addr_out, 5);
        checkOutput("t1_data", rd_data_out, 32'hDEADBEEF);
        checkOutput("t1_commit_busy", rs1_busy, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        checkOutput("t1_after_busy", rs1_busy, 0);

        // Pipeline and MDU collide; pipeline wins, MDU follows.
        applyStimulus(1, 3, 32'h11, 1, 7, 32'h22, 0, 0, 0, 0, 0);
        checkOutput("t2_addr", rd_addr_out, 3);
        checkOutput("t2_data", rd_data_out, 32'h11);
        checkOutput("t2_we", rd_we, 1);
        checkOutput("t2_ready", mdu_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 7, 32'h22, 0, 0, 0, 0, 0);
        checkOutput("t2b_addr", rd_addr_out, 7);
        checkOutput("t2b_data", rd_data_out, 32'h22);
        checkOutput("t2b_ready", mdu_ready, 1);
        tick();

        // Starvation: four denied cycles raise the stall.
        applyStimulus(1, 2, 32'h33, 1, 8, 32'h44, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        checkOutput("t3_stall_after3", wb_stall, 0);
        tick();
        checkOutput("t3_stall_after4", wb_stall, 1);
        checkOutput("t3_pipe_wins_addr", rd_addr_out, 2);
        checkOutput("t3_pipe_wins_ready", mdu_ready, 0);
        tick();
        checkOutput("t3_stall_held", wb_stall, 1);
        applyStimulus(0, 0, 0, 1, 8, 32'h44, 0, 0, 0, 0, 0);
        checkOutput("t3_grant_ready", mdu_ready, 1);
        checkOutput("t3_grant_addr", rd_addr_out, 8);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_stall_cleared", wb_stall, 0);

        // x0 is never tracked and MDU writes to it are dropped.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_x0_busy", rd_busy, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0);
        checkOutput("t4_x0_ready", mdu_ready, 1);
        checkOutput("t4_x0_we", rd_we, 0);
        tick();

        // Commit and re-issue of x9 in the same cycle.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9);
        tick();
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0, 9);
        checkOutput("t5_commit_rd_busy", rd_busy, 0);
        checkOutput("t5_commit_ready", mdu_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        checkOutput("t5_reissued_busy", rd_busy, 1);
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 9);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        checkOutput("t5_cleared_busy", rd_busy, 0);

        // Reset discards busy bits and the stall.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 32'h1, 1, 10, 32'hA, 0, 0, 4, 6, 0);
        checkOutput("t6_rs1_busy", rs1_busy, 1);
        checkOutput("t6_rs2_busy", rs2_busy, 1);
        tick();
        tick();
        tick();
        tick();
        checkOutput("t6_stall_set", wb_stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 6, 4);
        checkOutput("t6_rst_rs1", rs1_busy, 0);
        checkOutput("t6_rst_rs2", rs2_busy, 0);
        checkOutput("t6_rst_rd", rd_busy, 0);
        checkOutput("t6_rst_stall", wb_stall, 0);
        applyStimulus(1, 1, 32'h1, 1, 10, 32'hA, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        checkOutput("t6_cnt_restart3", wb_stall, 0);
        tick();
        checkOutput("t6_cnt_restart4", wb_stall, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_idle_clears", wb_stall, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
